// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the general register file: two writeback requesters,
// round-robin fairness, locked multi-beat bursts with idle timeout, registered write beat.
module regfile_wr_arbiter #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              locked
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t            state;
    logic              prio;
    logic [CNT_W-1:0]  idle_cnt;

    logic              gnt0;
    logic              gnt1;
    logic              accept;
    logic              acc_lock;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;

    // Grant selection; readies are suppressed while reset is held
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (state)
                ARB: begin
                    gnt0 = req0_valid && (!req1_valid || !prio);
                    gnt1 = req1_valid && !gnt0;
                end
                LOCK0:   gnt0 = req0_valid;
                LOCK1:   gnt1 = req1_valid;
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 || gnt1;
    assign acc_lock   = gnt0 ? req0_lock : req1_lock;
    assign acc_addr   = gnt0 ? req0_addr : req1_addr;
    assign acc_data   = gnt0 ? req0_data : req1_data;

    // Arbitration state, idle timeout and registered write beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            prio     <= 1'b0;
            idle_cnt <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            locked   <= 1'b0;
        end else begin
            we <= accept && (acc_addr != '0);
            if (accept) begin
                waddr    <= acc_addr;
                wdata    <= acc_data;
                idle_cnt <= '0;
                if (acc_lock) begin
                    state  <= gnt0 ? LOCK0 : LOCK1;
                    locked <= 1'b1;
                end else begin
                    state  <= ARB;
                    prio   <= gnt0;
                    locked <= 1'b0;
                end
            end else if (state != ARB) begin
                // Owner stayed silent; release once the idle budget is spent
                if (idle_cnt == IDLE_LAST) begin
                    state    <= ARB;
                    prio     <= (state == LOCK0);
                    idle_cnt <= '0;
                    locked   <= 1'b0;
                end else begin
                    idle_cnt <= idle_cnt + CNT_W'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model of the arbitration rules.
module tb_regfile_wr_arbiter;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned LOCK_MAX = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_lock, req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid, req1_lock, req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              we, locked;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_lock(req0_lock), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_lock(req1_lock), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .locked(locked)
    );

    int checks = 0;
    int failures = 0;

    // Model: owner = -1 when arbitrating, else the requester holding the lock
    int                m_owner, m_prio, m_idle;
    logic              m_we, m_locked;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;

    int   exp_gnt;
    logic obs_r0, obs_r1;

    function automatic int model_grant();
        if (rst) return -1;
        if (m_owner == 0) return req0_valid ? 0 : -1;
        if (m_owner == 1) return req1_valid ? 1 : -1;
        if (req0_valid && req1_valid) return m_prio;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_update(input int g);
        if (rst) begin
            m_owner = -1; m_prio = 0; m_idle = 0;
            m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_locked = 1'b0;
        end else begin
            if (g >= 0) begin
                m_waddr = (g == 0) ? req0_addr : req1_addr;
                m_wdata = (g == 0) ? req0_data : req1_data;
                m_we    = (m_waddr != 0);
                m_idle  = 0;
                if ((g == 0) ? req0_lock : req1_lock) begin
                    m_owner = g;
                end else begin
                    m_owner = -1;
                    m_prio  = 1 - g;
                end
            end else begin
                m_we = 1'b0;
                if (m_owner >= 0) begin
                    m_idle++;
                    if (m_idle == int'(LOCK_MAX)) begin
                        m_prio  = 1 - m_owner;
                        m_owner = -1;
                        m_idle  = 0;
                    end
                end
            end
            m_locked = (m_owner >= 0);
        end
    endtask

    task automatic drive(input logic v0, input logic l0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0, input logic v1, input logic l1,
                         input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        req0_valid = v0; req0_lock = l0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_lock = l1; req1_addr = a1; req1_data = d1;
    endtask

    // One clock: sample readies mid-cycle, clock, then settle just after the edge
    task automatic cycle();
        #3;
        exp_gnt = model_grant();
        obs_r0  = req0_ready;
        obs_r1  = req1_ready;
        @(posedge clk);
        model_update(exp_gnt);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 1'b1, 5'd4, 32'h2);
        cycle();
        cycle();
        checks++;
        if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got r0=%b r1=%b want 0 0", obs_r0, obs_r1);
        end
        checks++;
        if (we !== 1'b0 || waddr !== '0 || wdata !== '0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got we=%b waddr=%0d wdata=%h locked=%b want all 0",
                     we, waddr, wdata, locked);
        end
        rst = 1'b0;
    endtask

    task automatic test_alternate();
        int exp_seq [4] = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 5'd3, $urandom, 1'b1, 1'b0, 5'd4, $urandom);
            cycle();
            checks++;
            if (obs_r0 !== (exp_seq[i] == 0) || obs_r1 !== (exp_seq[i] == 1)) begin
                failures++;
                $display("FAIL alternate_grant[%0d]: got r0=%b r1=%b want grant %0d",
                         i, obs_r0, obs_r1, exp_seq[i]);
            end
            checks++;
            if (we !== 1'b1 || waddr !== ((exp_seq[i] == 0) ? 5'd3 : 5'd4)) begin
                failures++;
                $display("FAIL alternate_write[%0d]: got we=%b waddr=%0d want we=1 waddr=%0d",
                         i, we, waddr, (exp_seq[i] == 0) ? 3 : 4);
            end
        end
    endtask

    task automatic test_single();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd7, 32'hDEADBEEF);
        cycle();
        checks++;
        if (obs_r1 !== 1'b1 || obs_r0 !== 1'b0) begin
            failures++;
            $display("FAIL single_ready: got r0=%b r1=%b want 0 1", obs_r0, obs_r1);
        end
        checks++;
        if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_write: got we=%b waddr=%0d wdata=%h want 1 7 deadbeef",
                     we, waddr, wdata);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();
        checks++;
        if (we !== 1'b0 || waddr !== 5'd7) begin
            failures++;
            $display("FAIL single_idle: got we=%b waddr=%0d want we=0 waddr=7", we, waddr);
        end
    endtask

    task automatic test_burst();
        logic lk [3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, lk[k], ADDR_W'(11 + k), $urandom, 1'b1, 1'b0, 5'd20, 32'h55);
            cycle();
            checks++;
            if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin
                failures++;
                $display("FAIL burst_ready[%0d]: got r0=%b r1=%b want 1 0", k, obs_r0, obs_r1);
            end
            checks++;
            if (we !== 1'b1 || waddr !== ADDR_W'(11 + k) || locked !== (k < 2)) begin
                failures++;
                $display("FAIL burst_out[%0d]: got we=%b waddr=%0d locked=%b want 1 %0d %b",
                         k, we, waddr, locked, 11 + k, (k < 2));
            end
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd20, 32'h55);
        cycle();
        checks++;
        if (obs_r1 !== 1'b1) begin
            failures++;
            $display("FAIL burst_handover: got r1=%b want 1", obs_r1);
        end
    endtask

    task automatic test_timeout();
        drive(1'b1, 1'b1, 5'd5, 32'h77, 1'b1, 1'b0, 5'd6, 32'h88);
        cycle();
        checks++;
        if (obs_r0 !== 1'b1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL timeout_enter: got r0=%b locked=%b want 1 1", obs_r0, locked);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd6, 32'h88);
        for (int i = 1; i <= int'(LOCK_MAX); i++) begin
            cycle();
            checks++;
            if (obs_r1 !== 1'b0 || locked !== (i < int'(LOCK_MAX))) begin
                failures++;
                $display("FAIL timeout_idle[%0d]: got r1=%b locked=%b want 0 %b",
                         i, obs_r1, locked, (i < int'(LOCK_MAX)));
            end
        end
        cycle();
        checks++;
        if (obs_r1 !== 1'b1 || we !== 1'b1 || waddr !== 5'd6) begin
            failures++;
            $display("FAIL timeout_release: got r1=%b we=%b waddr=%0d want 1 1 6",
                     obs_r1, we, waddr);
        end
    endtask

    task automatic test_r0_write();
        drive(1'b1, 1'b0, 5'd0, 32'h1234, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();
        checks++;
        if (obs_r0 !== 1'b1 || we !== 1'b0) begin
            failures++;
            $display("FAIL r0_write: got r0=%b we=%b want ready=1 we=0", obs_r0, we);
        end
    endtask

    task automatic test_reset_mid_burst();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd9, 32'h99);
        cycle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd10, 32'hAA);
        cycle();
        checks++;
        if (obs_r1 !== 1'b1 || locked !== 1'b1 || we !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: got r1=%b locked=%b we=%b want 1 1 1", obs_r1, locked, we);
        end
        rst = 1'b1;
        cycle();
        checks++;
        if (obs_r1 !== 1'b0 || we !== 1'b0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_reset: got r1=%b we=%b locked=%b want 0 0 0", obs_r1, we, locked);
        end
        rst = 1'b0;
        drive(1'b1, 1'b0, 5'd14, 32'h14, 1'b1, 1'b0, 5'd15, 32'h15);
        cycle();
        checks++;
        if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0 || waddr !== 5'd14) begin
            failures++;
            $display("FAIL rstmid_after: got r0=%b r1=%b waddr=%0d want 1 0 14",
                     obs_r0, obs_r1, waddr);
        end
    endtask

    task automatic test_random();
        int vprob;
        for (int n = 0; n < 600; n++) begin
            vprob = ((n / 50) % 2 == 0) ? 75 : 20;
            rst = ($urandom_range(0, 149) == 0);
            req0_valid = ($urandom_range(0, 99) < vprob);
            req1_valid = ($urandom_range(0, 99) < vprob);
            req0_lock  = ($urandom_range(0, 2) == 0);
            req1_lock  = ($urandom_range(0, 2) == 0);
            req0_addr  = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
            req1_addr  = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
            req0_data  = $urandom;
            req1_data  = $urandom;
            cycle();
            checks++;
            if (obs_r0 !== (exp_gnt == 0) || obs_r1 !== (exp_gnt == 1)) begin
                failures++;
                $display("FAIL rand_ready[%0d]: got r0=%b r1=%b want grant %0d",
                         n, obs_r0, obs_r1, exp_gnt);
            end
            checks++;
            if (we !== m_we || waddr !== m_waddr || wdata !== m_wdata || locked !== m_locked) begin
                failures++;
                $display("FAIL rand_out[%0d]: got we=%b waddr=%0d wdata=%h locked=%b want %b %0d %h %b",
                         n, we, waddr, wdata, locked, m_we, m_waddr, m_wdata, m_locked);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        test_reset();
        test_alternate();
        test_single();
        test_burst();
        test_timeout();
        test_r0_write();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Arbitrates the general register file's single write port between two writeback requesters (req0: execute-stage result, req1: load/multi-cycle unit result). It supports round-robin fairness and locked bursts for multi-beat writes, and registers the winning beat onto the register file's we/waddr/wdata inputs. Writes to register 0 are accepted and consumed without asserting the write enable.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- LOCK_MAX, 8, idle cycles tolerated in a locked burst before forced release (range 1..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has a write beat
- req0_lock  in  1  requester 0 requests grant retention after this beat
- req0_addr  in  ADDR_W  destination register
- req0_data  in  DATA_W  write data
- req0_ready  out  1  beat accepted this cycle (combinational)
- req1_valid, req1_lock, req1_addr, req1_data, req1_ready  as requester 0
- we  out  1  register file write enable (registered)
- waddr  out  ADDR_W  register file write address (registered)
- wdata  out  DATA_W  register file write data (registered)
- locked  out  1  arbiter in a locked state (registered)

## Operation
- States: ARB, LOCK0, LOCK1. A 1-bit round-robin pointer `prio` names the preferred requester.
- ARB:
  - If only one requester is valid, it is granted.
  - If both are valid, requester `prio` is granted.
  - If neither is valid, no grant is made.
- LOCKk: only requester k can be granted. The other requester's ready is held at 0 regardless of its valid.
- Accept: reqk_ready = 1 exactly when requester k is granted. A beat transfers when valid and ready are both high. At most one ready is high per cycle.
- Transitions on an accepted beat from requester k:
  - lock=1: go to LOCKk and clear the idle counter.
  - lock=0: go to ARB and set prio = not k.
  - ARB with no accept: state and prio unchanged.
- Idle counter:
  - In LOCKk, each cycle without an accepted beat from k increments the counter.
  - When the counter reaches LOCK_MAX, the block goes to ARB, sets prio = not k, and clears the counter. The forced release is registered, so the other requester may win on the following cycle.
  - The counter is held at 0 outside lock states.
- Output stage, registered on every clock edge:
  - we = accepted && (addr != 0)
  - waddr and wdata load the accepted beat's address and data when a beat is accepted; otherwise they hold their values.
  - An r0 beat completes the handshake but produces we=0.
- locked = 1 in LOCK0 or LOCK1.
- Requester inputs need not be stable while ready is low. Only the accept cycle is sampled.
- Same-address writes from both requesters are serialized in grant order. The later grant lands last.

## Timing
- Reset values: we=0, waddr=0, wdata=0, locked=0, state=ARB, prio=0, idle counter=0. While rst is high, both readies are 0.
- Handshake is zero-latency: ready is asserted in the same cycle as valid.
- Write latency: a beat accepted at edge n appears on we/waddr/wdata during cycle n+1. It is written into the register file at edge n+1. Read-after-write in cycle n+1 is served by the register file's internal forwarding.
- Throughput: one beat per cycle. There are no bubbles between back-to-back grants, including a switch from one requester to the other.
- Reset asserted mid-burst: the block returns to ARB with prio=0, and the pending output beat is dropped (we=0 next cycle).
- Forced release takes effect at the edge where the counter equals LOCK_MAX. A late beat from k in that same cycle is accepted, and acceptance takes precedence over the release.

## Test plan
- After reset, req0 and req1 both valid every cycle with addrs 3 and 4 → grants alternate 0,1,0,1. The we/waddr sequence is 3,4,3,4, each one cycle after its accept.
- req1 only valid, addr 7, data 0xDEADBEEF, one cycle → req1_ready=1 that cycle; next cycle we=1, waddr=7, wdata=0xDEADBEEF; the cycle after, we=0.
- req0 sends 3 beats with lock=1,1,0 while req1 is continuously valid → req1_ready=0 for all three; locked=1 during the burst; req1 granted on the cycle after the final beat.
- req0 sends one lock=1 beat and then goes silent, LOCK_MAX=8, req1 valid → locked drops after 8 idle cycles; req1 granted on the following cycle.
- req0 writes addr 0, data 0x1234 → req0_ready=1, we stays 0.
- Reset pulsed during LOCK1 with a beat accepted in the reset-preceding cycle → after reset: we=0, locked=0; with both requesters valid, req0 wins first.
